// File: rtl/osc_mon_pkg.sv
// Shared types and helpers for the oscillator frequency monitors.
// Holds the monitor FSM states, settle length and counter width helper.
package osc_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE
    } mon_state_e;

    localparam int SETTLE_CYCLES = 3;

    // Bits needed to hold the values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous clock-like input,
// plus one extra flop to produce a single-cycle rising-edge strobe.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES:0] sr;

    // Shift the raw input through the synchronizer and delay flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-1:0], d};
        end
    end

    assign rise = sr[SYNC_STAGES-1] & ~sr[SYNC_STAGES];

endmodule

// File: rtl/osc_freq_monitor.sv
// Counts monitored-clock rising edges over a fixed window of system
// clocks, flags out-of-range frequency and a stopped monitored clock.
module osc_freq_monitor
    import osc_mon_pkg::*;
#(
    parameter int WINDOW_CYCLES = 50000,
    parameter int CNT_W         = 16,
    parameter int LO_LIMIT      = 990,
    parameter int HI_LIMIT      = 1010,
    parameter int STALL_CYCLES  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             freq_ok,
    output logic             clk_lost
);

    localparam int WIN_W = cnt_width(WINDOW_CYCLES);
    localparam int STL_W = cnt_width(STALL_CYCLES + 1);

    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [STL_W-1:0] STL_MAX    = STL_W'(STALL_CYCLES);
    localparam logic [1:0]       SETTLE_END = 2'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    mon_state_e state;
    mon_state_e state_nxt;

    logic             rise;
    logic [1:0]       settle_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt;
    logic [STL_W-1:0] stall_cnt;
    logic [31:0]      edge_ext;
    logic             win_last;
    logic             in_range;

    sync_edge_detect #(
        .SYNC_STAGES (2)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (mon_clk),
        .rise (rise)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a low enable always wins and drops to IDLE.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nxt = SETTLE;
                SETTLE:  if (settle_cnt == SETTLE_END) state_nxt = MEASURE;
                MEASURE: state_nxt = MEASURE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Edge count including any rise in the current cycle, saturating.
    always_comb begin
        edge_nxt = edge_cnt;
        if (rise && edge_cnt != CNT_MAX) begin
            edge_nxt = edge_cnt + 1'b1;
        end
    end

    assign win_last = (state == MEASURE) && (win_cnt == WIN_LAST);
    assign edge_ext = 32'(edge_nxt);
    assign in_range = (edge_ext >= 32'(LO_LIMIT)) &&
                      (edge_ext <= 32'(HI_LIMIT));

    // Settle timer: lets the synchronizer flush before counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (state != SETTLE) begin
            settle_cnt <= '0;
        end else begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    // Window and edge counters; restart together at each window end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else if (state != MEASURE || win_last) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            win_cnt  <= win_cnt + 1'b1;
            edge_cnt <= edge_nxt;
        end
    end

    // Stall counter: cycles since the last monitored edge, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state != MEASURE || rise) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Result registers; a window closing with enable low is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            count_valid <= 1'b0;
            freq_ok     <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (win_last && enable) begin
                count       <= edge_nxt;
                count_valid <= 1'b1;
                freq_ok     <= in_range;
            end else if (state_nxt != MEASURE) begin
                freq_ok <= 1'b0;
            end
        end
    end

    assign clk_lost = (state == MEASURE) && (stall_cnt == STL_MAX);

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Self-checking bench for osc_freq_monitor with a shortened window.
// Edge counts are predicted from recorded monitored-edge timestamps.
`timescale 1ns/1ps
module tb_osc_freq_monitor;

    localparam int  W     = 200;
    localparam int  CW    = 5;
    localparam int  LO    = 19;
    localparam int  HI    = 21;
    localparam int  STALL = 32;
    localparam int  CMAX  = (1 << CW) - 1;
    localparam real TCLK  = 20.0;

    typedef struct {
        int period;
        int cnt_lo;
        int cnt_hi;
        int ok;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          mon_clk = 1'b0;
    logic [CW-1:0] count;
    logic          count_valid;
    logic          freq_ok;
    logic          clk_lost;

    bit      mon_run  = 1'b1;
    realtime mon_half = 100.0;
    realtime edges[$];

    int checks = 0;
    int passed = 0;

    osc_freq_monitor #(
        .WINDOW_CYCLES (W),
        .CNT_W         (CW),
        .LO_LIMIT      (LO),
        .HI_LIMIT      (HI),
        .STALL_CYCLES  (STALL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mon_clk     (mon_clk),
        .count       (count),
        .count_valid (count_valid),
        .freq_ok     (freq_ok),
        .clk_lost    (clk_lost)
    );

    always #10 clk = ~clk;

    // Monitored oscillator; every rising edge is timestamped.
    always begin
        if (mon_run) begin
            mon_clk = 1'b1;
            edges.push_back($realtime);
            #(mon_half);
            mon_clk = 1'b0;
            #(mon_half);
        end else begin
            mon_clk = 1'b0;
            #1;
        end
    end

    task automatic chk(input string name, input int act,
                       input int lo, input int hi);
        checks++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, want %0d..%0d",
                      name, act, lo, hi);
    endtask

    // Edges whose synchronized rise lands inside the window ending at tend.
    function automatic int model_cnt(input realtime tend);
        int n = 0;
        foreach (edges[i])
            if (edges[i] > tend - (W + 2) * TCLK &&
                edges[i] <= tend - 2 * TCLK)
                n++;
        return n;
    endfunction

    // Every reported window is checked against the timestamp model.
    bit prev_v = 1'b0;
    always @(posedge clk) begin
        int n, lo, hi, ok;
        #1;
        if (count_valid) begin
            n  = model_cnt($realtime - 1.0);
            lo = (n - 1 < 0) ? 0 : n - 1;
            hi = n + 1;
            if (lo > CMAX) lo = CMAX;
            if (hi > CMAX) hi = CMAX;
            chk("model_count", int'(count), lo, hi);
            ok = (int'(count) >= LO && int'(count) <= HI) ? 1 : 0;
            chk("freq_ok_rule", int'(freq_ok), ok, ok);
            chk("pulse_width", int'(prev_v), 0, 0);
        end
        prev_v = count_valid;
    end

    // Cycles until the next count_valid; 0 if the bound expires.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 3 * W; i++) begin
            @(posedge clk);
            #1;
            if (count_valid) begin
                n = i;
                return;
            end
        end
        $display("FAIL wait_valid: got timeout, want pulse");
        checks++;
    endtask

    vec_t vecs[4];

    initial begin
        int n;
        int saved;
        int any_v;
        int cyc;
        int sz;
        realtime t0;

        vecs[0] = '{200, 19, 21, 1};
        vecs[1] = '{160, 24, 26, 0};
        vecs[2] = '{100, 31, 31, 0};
        vecs[3] = '{250, 15, 17, 0};

        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0, 0);
        chk("rst_valid", int'(count_valid), 0, 0);
        chk("rst_ok", int'(freq_ok), 0, 0);
        chk("rst_lost", int'(clk_lost), 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // First pulse: sampled edge is cycle 1, pulse after 3 + W more.
        @(negedge clk);
        enable = 1'b1;
        wait_valid(n);
        chk("first_pulse", n, W + 4, W + 4);
        wait_valid(n);
        chk("pulse_spacing", n, W, W);

        // Table: fixed frequencies, first window after a change skipped.
        for (int v = 0; v < 4; v++) begin
            mon_half = vecs[v].period / 2.0;
            wait_valid(n);
            for (int k = 0; k < 2; k++) begin
                wait_valid(n);
                chk($sformatf("tbl%0d_count", v), int'(count),
                    vecs[v].cnt_lo, vecs[v].cnt_hi);
                chk($sformatf("tbl%0d_ok", v), int'(freq_ok),
                    vecs[v].ok, vecs[v].ok);
            end
        end

        // Random frequencies, checked by the timestamp model.
        for (int r = 0; r < 8; r++) begin
            mon_half = real'($urandom_range(45, 200));
            repeat ($urandom_range(0, 50)) @(posedge clk);
            wait_valid(n);
        end

        // Stop the monitored clock mid-window, then restart it.
        mon_half = 100.0;
        wait_valid(n);
        wait_valid(n);
        repeat (50) @(posedge clk);
        mon_run = 1'b0;
        cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (clk_lost) begin
                cyc = int'(($realtime - 1.0 - edges[$]) / TCLK);
                break;
            end
        end
        chk("lost_delay", cyc, STALL - 3, STALL + 4);
        sz = edges.size();
        @(negedge clk);
        mon_run = 1'b1;
        for (int i = 0; i < 100 && edges.size() == sz; i++) #1;
        t0 = edges[$];
        for (int i = 0; i < 20 && clk_lost; i++) begin
            @(posedge clk);
            #1;
        end
        chk("lost_clear_ns", int'($realtime - t0), 0, 85);
        wait_valid(n);
        chk("stall_count", int'(count), 14, 18);
        chk("stall_ok", int'(freq_ok), 0, 0);

        // Drop enable mid-window: nothing reported, count held.
        wait_valid(n);
        chk("pre_drop_ok", int'(freq_ok), 1, 1);
        saved = int'(count);
        repeat (100) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        any_v = 0;
        for (int i = 0; i < W + 20; i++) begin
            @(posedge clk);
            #1;
            if (count_valid) any_v = 1;
        end
        chk("drop_no_pulse", any_v, 0, 0);
        chk("drop_ok", int'(freq_ok), 0, 0);
        chk("drop_count_hold", int'(count), saved, saved);
        @(negedge clk);
        enable = 1'b1;
        wait_valid(n);
        chk("reenable_pulse", n, W + 4, W + 4);

        // Asynchronous reset mid-window, then restart.
        wait_valid(n);
        repeat (150) @(posedge clk);
        chk("pre_rst_ok", int'(freq_ok), 1, 1);
        #5;
        rst = 1'b1;
        #1;
        chk("arst_count", int'(count), 0, 0);
        chk("arst_ok", int'(freq_ok), 0, 0);
        chk("arst_valid", int'(count_valid), 0, 0);
        chk("arst_lost", int'(clk_lost), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(n);
        chk("post_rst_pulse", n, W + 4, W + 4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/osc_freq_monitor.md
# osc_freq_monitor

Measures the frequency of an on-chip oscillator output, such as the 1 MHz RC or crystal oscillator, against the fabric system clock. It counts the monitored clock's rising edges over a fixed window of system-clock cycles. It flags an out-of-range frequency and a stopped clock. It sits in the fabric clock domain next to the oscillator/CCC wrapper and reports to housekeeping telemetry.

## Interface
Parameters:
- WINDOW_CYCLES, 50000: system-clock cycles per measurement window (1 ms at 50 MHz); minimum 8.
- CNT_W, 16: width of the edge count; the count saturates at 2^CNT_W-1.
- LO_LIMIT, 990: lowest count accepted as in range (inclusive).
- HI_LIMIT, 1010: highest count accepted as in range (inclusive).
- STALL_CYCLES, 256: system-clock cycles with no monitored edge before clk_lost asserts.

Ports:
- clk  in  1  fabric system clock, 50 MHz.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  level; 1 runs measurements, 0 idles.
- mon_clk  in  1  monitored oscillator output; asynchronous to clk; frequency must be below clk/4.
- count  out  CNT_W  edge count from the last completed window.
- count_valid  out  1  one-cycle pulse when count updates.
- freq_ok  out  1  last completed window satisfied LO_LIMIT <= count <= HI_LIMIT.
- clk_lost  out  1  no monitored edge seen for STALL_CYCLES cycles.

## Operation
- mon_clk passes through a 2-flop synchronizer and then a third flop. rise = sync2 & ~sync3.
- State machine states:
  - IDLE: entered on reset, or in the cycle enable is seen low; exits when enable=1.
  - SETTLE: 3 cycles to flush the synchronizer. Edges seen here are ignored.
  - MEASURE: the window counter runs 0..WINDOW_CYCLES-1.
- Transitions:
  - IDLE -> SETTLE when enable=1.
  - SETTLE -> MEASURE after 3 cycles.
  - MEASURE stays in MEASURE, back to back with no gap between windows.
  - Any state -> IDLE when enable=0. Any partial window is discarded.
- Edge counter:
  - Cleared at the start of each window.
  - Increments on rise and saturates at all-ones.
  - A rise in the terminal cycle (window = WINDOW_CYCLES-1) is included in the latched count.
- In the terminal cycle, count, count_valid and freq_ok are registered. The new window's counter starts at 0, or at 1 if rise occurs in the first cycle.
- Stall counter:
  - Runs only in MEASURE and is cleared on every rise.
  - Saturates at STALL_CYCLES.
  - clk_lost = 1 while it equals STALL_CYCLES; clears in the cycle after the next rise.
- Leaving MEASURE clears freq_ok and clk_lost; count holds its last value.
- Reset values: count=0, count_valid=0, freq_ok=0, clk_lost=0, state=IDLE.

## Timing
- A mon_clk rising edge reaches rise 2-3 clk cycles later, depending on synchronizer capture.
- First count_valid arrives 3 + WINDOW_CYCLES cycles after enable is sampled high. After that, one pulse every WINDOW_CYCLES cycles, each lasting exactly 1 cycle.
- count and freq_ok change only in the same cycle count_valid is high.
- Reset mid-window: all outputs return to reset values asynchronously, and no count_valid pulse is produced.
- enable low during the terminal cycle: no pulse is produced, and IDLE takes priority.
- Counts are reported without correction. A ±1 count of quantization from window alignment is expected, and the limits must absorb it.

## Structure
- Package osc_mon_pkg holds:
  - The state enum (IDLE, SETTLE, MEASURE).
  - SETTLE_CYCLES = 3.
  - A helper that computes counter widths with clog2 of WINDOW_CYCLES and STALL_CYCLES.
- One sub-module, sync_edge_detect: the 3-flop synchronizer plus rise output, with parameterized sync depth. It is reused by the other clock-domain monitors.
- The top level holds the FSM, the window, edge and stall counters, and the output registers. Expected size is about 150-200 lines.

## Test plan
- clk 50 MHz, mon_clk 1 MHz, defaults:
  - Each count_valid reports count of 999-1001 with freq_ok=1.
  - First pulse arrives at enable + 50003 cycles; later pulses are spaced 50000 cycles apart.
- mon_clk 1.05 MHz: count 1049-1051, freq_ok=0. Set LO_LIMIT=HI_LIMIT=1000 with an exactly phase-aligned 1 MHz stimulus: freq_ok=1.
- Stop mon_clk mid-window: clk_lost=1 within 256 +/- 3 cycles of the last edge. Restart: clk_lost=0 within 4 cycles of the first new edge. The next full window reports the reduced count.
- CNT_W=8, mon_clk 10 MHz, WINDOW_CYCLES=50000: count=255, saturated, with no wrap.
- Drop enable at window cycle 25000: no count_valid, freq_ok=0, count keeps its old value. Re-enable: the next pulse arrives 50003 cycles later.
- Assert rst asynchronously at window cycle 30000: all outputs are 0 immediately. After release with enable=1: the first pulse arrives 50003 cycles after the first enabled edge.
